instruction_fetch_unit: RTL and testbench

- Consumer end of the 16-bit, 32-word instruction ROM interface (readAddress, readData, readData2).
- Holds the program counter and drives readAddress.
- Captures two words per ROM access into a 2-entry instruction buffer.
- Issues one instruction at a time to the datapath over a valid/ready handshake, resolves branches, and stops on HALT.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/instr_field_decoder.sv | 15 +
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, instruction field positions and fetch state encoding
package cpu_pkg;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [15:0] HALT_WORD = 16'h1FFF;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int TGT_MSB = 12;
  localparam int TGT_LSB = 8;
  localparam int TGT_W = TGT_MSB - TGT_LSB + 1;
  typedef enum logic [1:0] {IDLE, FILL, ISSUE, HALTED} fetch_state_t;
endpackage

// File: rtl/instr_field_decoder.sv
// instr_field_decoder: combinational split of an instruction word into opcode, branch/halt flags and target
module instr_field_decoder
  import cpu_pkg::*;
(
  input  logic [15:0]      instr,
  output logic [2:0]       opcode,
  output logic             isBranch,
  output logic             isHalt,
  output logic [TGT_W-1:0] branchTarget
);
  assign opcode = instr[OP_MSB:OP_LSB];
  assign isBranch = opcode == OP_BRANCH;
  assign isHalt = instr == HALT_WORD;
  assign branchTarget = instr[TGT_MSB:TGT_LSB];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: pc, two-word ROM prefetch buffer and valid/ready issue with branch and halt handling
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  readAddress,
  input  logic [INSTR_W-1:0] readData,
  input  logic [INSTR_W-1:0] readData2,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instrPc,
  output logic               instrValid,
  input  logic               instrReady,
  output logic               isBranch,
  input  logic               branchTaken,
  output logic               halted
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, buf0_pc, buf1_pc;
  logic [INSTR_W-1:0] buf0, buf1;
  logic [1:0] count;
  logic [2:0] dec_op;
  logic dec_branch, dec_halt, hs, take_br;
  logic [TGT_W-1:0] dec_tgt;
  instr_field_decoder u_dec (
    .instr(buf0),
    .opcode(dec_op),
    .isBranch(dec_branch),
    .isHalt(dec_halt),
    .branchTarget(dec_tgt)
  );
  assign readAddress = pc;
  assign instr = buf0;
  assign instrPc = buf0_pc;
  assign instrValid = state == ISSUE;
  assign isBranch = instrValid && (dec_op == OP_BRANCH);
  assign halted = state == HALTED;
  assign hs = instrValid && instrReady;
  assign take_br = hs && dec_branch && branchTaken;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = start ? FILL : IDLE;
    else if (state == FILL)
      state_n = ISSUE;
    else if (hs)
      state_n = dec_halt ? HALTED : (take_br || count == 2'd1) ? FILL : ISSUE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      count <= '0;
      buf0 <= '0;
      buf1 <= '0;
      buf0_pc <= '0;
      buf1_pc <= '0;
    end else begin
      state <= state_n;
      if (state == FILL) begin
        buf0 <= readData;
        buf0_pc <= pc;
        buf1 <= readData2;
        buf1_pc <= pc + 1'b1;
        count <= 2'd2;
        pc <= pc + 2'd2;
      end else if (hs && dec_halt) begin
        buf0 <= '0;
        buf1 <= '0;
        buf0_pc <= '0;
        buf1_pc <= '0;
        count <= '0;
      end else if (take_br) begin
        // the second buffered word is dropped by emptying the buffer
        count <= '0;
        pc <= dec_tgt;
      end else if (hs) begin
        buf0 <= buf1;
        buf0_pc <= buf1_pc;
        count <= count - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of reset, issue, backpressure, branches, wrap and halt
module tb_instruction_fetch_unit;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic instrReady = 0;
  logic branchTaken = 0;
  logic [4:0] readAddress, instrPc;
  logic [15:0] readData, readData2, instr;
  logic instrValid, isBranch, halted;
  logic [15:0] rom [32];
  int checks = 0;
  int fails = 0;
  int obs_pc [32];
  logic obs_br [32];
  logic [4:0] obs_ra [32];
  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .readAddress(readAddress),
    .readData(readData),
    .readData2(readData2),
    .instr(instr),
    .instrPc(instrPc),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .isBranch(isBranch),
    .branchTaken(branchTaken),
    .halted(halted)
  );
  always #5 clk = ~clk;
  assign readData = rom[readAddress];
  assign readData2 = rom[readAddress + 5'd1];
  task automatic load_seq();
    for (int i = 0; i < 32; i++) rom[i] = 16'h2000 | 16'(i);
  endtask
  task automatic do_reset();
    reset = 1;
    start = 0;
    instrReady = 0;
    branchTaken = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic go();
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    instrReady = 1;
    for (int i = 0; i < n; i++) begin
      obs_pc[i] = instrValid ? int'(instrPc) : -1;
      obs_br[i] = isBranch;
      obs_ra[i] = readAddress;
      @(posedge clk);
      #1;
    end
    instrReady = 0;
  endtask
  task automatic test_reset_start();
    load_seq();
    rom[1] = 16'h2011;
    do_reset();
    checks++; if (readAddress !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", readAddress); end
    checks++; if (instrValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instrValid); end
    checks++; if (instr !== 16'h0 || instrPc !== 5'd0) begin fails++; $display("FAIL reset_instr got %h/%0d want 0000/0", instr, instrPc); end
    checks++; if (halted !== 1'b0 || isBranch !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b want 00", halted, isBranch); end
    start = 1;
    @(posedge clk);
    #1 start = 0;
    checks++; if (instrValid !== 1'b0) begin fails++; $display("FAIL fill_bubble got %b want 0", instrValid); end
    @(posedge clk);
    #1;
    checks++; if (instrValid !== 1'b1 || instr !== 16'h2000 || instrPc !== 5'd0) begin fails++; $display("FAIL first_issue got %b %h %0d want 1 2000 0", instrValid, instr, instrPc); end
    instrReady = 1;
    @(posedge clk);
    #1 instrReady = 0;
    checks++; if (instrValid !== 1'b1 || instr !== 16'h2011 || instrPc !== 5'd1) begin fails++; $display("FAIL second_issue got %b %h %0d want 1 2011 1", instrValid, instr, instrPc); end
  endtask
  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (instrValid !== 1'b1 || instr !== 16'h2011 || instrPc !== 5'd1 || readAddress !== 5'd2) begin
        fails++;
        $display("FAIL hold_%0d got v=%b %h pc=%0d ra=%0d want 1 2011 1 2", i, instrValid, instr, instrPc, readAddress);
      end
    end
  endtask
  task automatic test_taken_branch();
    int exp_pc [12] = '{0, 1, -1, 2, 3, -1, 4, 5, -1, 9, 10, -1};
    load_seq();
    rom[5] = 16'hA921;
    do_reset();
    go();
    branchTaken = 1;
    run(12);
    branchTaken = 0;
    for (int i = 0; i < 12; i++) begin
      checks++; if (obs_pc[i] !== exp_pc[i]) begin fails++; $display("FAIL taken_pc[%0d] got %0d want %0d", i, obs_pc[i], exp_pc[i]); end
      checks++; if (obs_br[i] !== (exp_pc[i] == 5)) begin fails++; $display("FAIL taken_isbr[%0d] got %b want %b", i, obs_br[i], exp_pc[i] == 5); end
    end
  endtask
  task automatic test_not_taken_branch();
    int exp_pc [12] = '{0, 1, -1, 2, 3, -1, 4, 5, -1, 6, 7, -1};
    load_seq();
    rom[5] = 16'hA921;
    do_reset();
    go();
    run(12);
    for (int i = 0; i < 12; i++) begin
      checks++; if (obs_pc[i] !== exp_pc[i]) begin fails++; $display("FAIL ntaken_pc[%0d] got %0d want %0d", i, obs_pc[i], exp_pc[i]); end
    end
  endtask
  task automatic test_wrap();
    int exp_pc [14] = '{0, 1, -1, 2, 3, -1, 4, 5, -1, 31, 0, -1, 1, 2};
    load_seq();
    rom[5] = 16'hBF21;
    do_reset();
    go();
    branchTaken = 1;
    run(14);
    branchTaken = 0;
    for (int i = 0; i < 14; i++) begin
      checks++; if (obs_pc[i] !== exp_pc[i]) begin fails++; $display("FAIL wrap_pc[%0d] got %0d want %0d", i, obs_pc[i], exp_pc[i]); end
    end
    checks++; if (obs_ra[9] !== 5'd1) begin fails++; $display("FAIL wrap_addr got %0d want 1", obs_ra[9]); end
  endtask
  task automatic test_halt();
    int exp_pc [16] = '{0, 1, -1, 2, 3, -1, 4, 5, -1, 6, 7, -1, 8, 9, -1, 10};
    load_seq();
    rom[10] = 16'h1FFF;
    do_reset();
    go();
    run(16);
    for (int i = 0; i < 16; i++) begin
      checks++; if (obs_pc[i] !== exp_pc[i]) begin fails++; $display("FAIL halt_pc[%0d] got %0d want %0d", i, obs_pc[i], exp_pc[i]); end
    end
    checks++; if (halted !== 1'b1 || instrValid !== 1'b0) begin fails++; $display("FAIL halt_state got h=%b v=%b want 1 0", halted, instrValid); end
    checks++; if (instr !== 16'h0) begin fails++; $display("FAIL halt_clear got %h want 0000", instr); end
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b1 || instrValid !== 1'b0 || readAddress !== 5'd12) begin fails++; $display("FAIL halt_start got h=%b v=%b ra=%0d want 1 0 12", halted, instrValid, readAddress); end
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    checks++; if (halted !== 1'b0 || instrValid !== 1'b0 || readAddress !== 5'd0) begin fails++; $display("FAIL halt_reset got h=%b v=%b ra=%0d want 0 0 0", halted, instrValid, readAddress); end
    go();
    checks++; if (instrValid !== 1'b1 || instr !== 16'h2000 || instrPc !== 5'd0) begin fails++; $display("FAIL restart got %b %h %0d want 1 2000 0", instrValid, instr, instrPc); end
  endtask
  task automatic test_reset_midflight();
    load_seq();
    do_reset();
    go();
    instrReady = 1;
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    instrReady = 0;
    checks++; if (instrValid !== 1'b0 || readAddress !== 5'd0 || instrPc !== 5'd0 || instr !== 16'h0) begin fails++; $display("FAIL mid_reset got v=%b ra=%0d pc=%0d %h want 0 0 0 0000", instrValid, readAddress, instrPc, instr); end
  endtask
  initial begin
    test_reset_start();
    test_backpressure();
    test_taken_branch();
    test_not_taken_branch();
    test_wrap();
    test_halt();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
